pixel_sink_fb: RTL and testbench

- Receiving end of the x/y/colour/plot pixel interface that the drawing datapath drives.
- Buffers incoming plot requests in a small FIFO and commits them to an internal WIDTH x HEIGHT x 3-bit framebuffer.
- Continuously raster-scans the framebuffer for display or readback logic.
- Provides a whole-screen clear operation.

---
 rtl/pixel_sink_fb.sv | 173 +++++++++++++++++
 tb/tb_pixel_sink_fb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sink_fb.sv
// Pixel sink: plot FIFO feeding a single-port WIDTH x HEIGHT x 3-bit framebuffer, with a raster scanner and whole-screen clear.
// Optional out-of-range plot flag enabled by defining OOB_FLAG_EN.
module pixel_sink_fb #(
  parameter int          WIDTH        = 160,
  parameter int          HEIGHT       = 120,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       plot,
  output logic       ready,
  input  logic       clear,
  output logic       busy,
  input  logic       scan_en,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       scan_valid,
  output logic       frame_start,
`ifdef OOB_FLAG_EN
  output logic       oob_flag,
`endif
  output logic       state_dbg
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  // Handshake: a plot is taken on a rising edge where plot=1 and ready=1;
  // ready comes from the registered FIFO count, so a same-edge pop never frees a slot early.

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } entry_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clear_addr;
  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  entry_t          head;
  logic [2:0]      fb_mem [NPIX];
  logic [7:0]      sx;
  logic [6:0]      sy;

  logic          in_range, consume, push, pop, clear_go;
  logic          clear_wr, fifo_wr, scan_rd, mem_we;
  logic [AW-1:0] mem_waddr;
  logic [2:0]    mem_wdata;

  function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return AW'(32'(y) * 32'(WIDTH) + 32'(x));
  endfunction

  assign ready     = (count != FULL_CNT);
  assign busy      = (state == CLEAR);
  assign state_dbg = (state == CLEAR);
  assign head      = fifo_mem[rd_ptr];

  assign in_range = (32'(x_in) < 32'(WIDTH)) && (32'(y_in) < 32'(HEIGHT));
  assign consume  = plot && ready;
  assign push     = consume && in_range;
  assign clear_go = clear && (state == RUN);
  assign pop      = (state == RUN) && (count != '0);

  // Arbitration for the single memory port: clear write, then FIFO write, then scan read.
  assign clear_wr = (state == CLEAR);
  assign fifo_wr  = pop;
  assign scan_rd  = scan_en && !clear_wr && !fifo_wr && !clear_go;
  assign mem_we   = !reset && (clear_wr || fifo_wr);

  always_comb begin
    mem_waddr = pix_addr(head.x, head.y);
    mem_wdata = head.colour;
    if (clear_wr) begin
      mem_waddr = clear_addr;
      mem_wdata = CLEAR_COLOUR;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (clear) state_nxt = CLEAR;
      CLEAR:   if (clear_addr == LAST_ADDR) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)         clear_addr <= '0;
    else if (clear_go) clear_addr <= '0;
    else if (clear_wr) clear_addr <= clear_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{x: x_in, y: y_in, colour: colour_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Framebuffer contents survive reset; only clear initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) fb_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx          <= '0;
      sy          <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
      scan_colour <= '0;
      scan_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      scan_valid  <= scan_rd;
      frame_start <= scan_rd && (sx == '0) && (sy == '0);
      if (scan_rd) begin
        scan_colour <= fb_mem[pix_addr(sx, sy)];
        scan_x      <= sx;
        scan_y      <= sy;
        if (sx == 8'(WIDTH - 1)) begin
          sx <= '0;
          if (sy == 7'(HEIGHT - 1)) sy <= '0;
          else                      sy <= sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

`ifdef OOB_FLAG_EN
  // A same-edge out-of-range plot wins over the clear that would reset the flag.
  always_ff @(posedge clk) begin
    if (reset)                      oob_flag <= 1'b0;
    else if (consume && !in_range)  oob_flag <= 1'b1;
    else if (clear_go)              oob_flag <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pixel_sink_fb.sv
// Bench for pixel_sink_fb: directed scenarios plus random plots, checked against a frame/queue reference model.
module tb_pixel_sink_fb;

  localparam int WIDTH = 160;
  localparam int HEIGHT = 120;
  localparam int DEPTH = 4;
  localparam int NPIX = WIDTH * HEIGHT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic       scan_en = 1'b0;
  logic       ready, busy, scan_valid, frame_start, state_dbg;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
`ifdef OOB_FLAG_EN
  logic       oob_flag;
`endif

  pixel_sink_fb #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(DEPTH), .CLEAR_COLOUR(3'b000)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot(plot), .ready(ready), .clear(clear), .busy(busy), .scan_en(scan_en),
    .scan_x(scan_x), .scan_y(scan_y), .scan_colour(scan_colour),
    .scan_valid(scan_valid), .frame_start(frame_start),
`ifdef OOB_FLAG_EN
    .oob_flag(oob_flag),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct { int x; int y; logic [2:0] c; } plot_t;

  int          total = 0;
  int          bad = 0;
  logic [18:0] exp_q[$];          // {x, y, colour, frame_start}
  logic [2:0]  model_fb [NPIX];
  plot_t       pend_q[$];
  bit          m_clearing = 0;
  int          m_clr_idx = 0;
  int          m_pos = 0;
  bit          m_oob = 0;
  bit          m_rdy, m_clear_go;
  plot_t       m_p;
  bit          mon_on = 0;
  int          invalid_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per edge: one memory access chosen by priority (clear, queued plot, scan), then accept.
  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
      m_clearing = 0;
      m_pos = 0;
      m_oob = 0;
    end else begin
      m_rdy = (pend_q.size() < DEPTH);
      m_clear_go = clear && !m_clearing;
      if (m_clearing) begin
        model_fb[m_clr_idx] = 3'b000;
        m_clr_idx++;
        if (m_clr_idx == NPIX) m_clearing = 0;
      end else if (pend_q.size() > 0) begin
        m_p = pend_q.pop_front();
        model_fb[m_p.y * WIDTH + m_p.x] = m_p.c;
      end else if (scan_en && !m_clear_go) begin
        exp_q.push_back({8'(m_pos % WIDTH), 7'(m_pos / WIDTH), model_fb[m_pos], 1'(m_pos == 0)});
        m_pos = (m_pos + 1) % NPIX;
      end
      if (m_clear_go) begin
        m_clearing = 1;
        m_clr_idx = 0;
        m_oob = 0;
      end
      if (plot && m_rdy) begin
        if (int'(x_in) < WIDTH && int'(y_in) < HEIGHT) pend_q.push_back('{int'(x_in), int'(y_in), colour_in});
        else m_oob = 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [18:0] exp_pix;
  always @(negedge clk) begin
    if (mon_on) begin
      if (!scan_valid) invalid_cnt++;
      if (scan_valid) begin
        if (exp_q.size() == 0) check("scan_unexpected", 1, 0);
        else begin
          exp_pix = exp_q.pop_front();
          check("scan_pixel", {scan_x, scan_y, scan_colour, frame_start}, exp_pix);
        end
      end else if (exp_q.size() != 0) begin
        check("scan_missing", 0, 1);
        exp_q.delete();
      end
      check("ready", ready, pend_q.size() < DEPTH);
      check("busy", busy, m_clearing);
      check("state", state_dbg, m_clearing);
`ifdef OOB_FLAG_EN
      check("oob_flag", oob_flag, m_oob);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic do_plot(input int x, input int y, input logic [2:0] c);
    bit acc = 0;
    plot = 1'b1;
    x_in = 8'(x);
    y_in = 7'(y);
    colour_in = c;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("plot_timeout", 0, 1);
    plot = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    for (int i = 0; i < 20000 && busy; i++) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  int busy_cycles, vcnt, fs_cnt, inv0;

  initial begin
    tick(2);
    reset = 1'b0;
    mon_on = 1;
    @(negedge clk);
    check("rst_scan_x", scan_x, 0);
    check("rst_scan_y", scan_y, 0);
    check("rst_scan_colour", scan_colour, 0);
    check("rst_frame_start", frame_start, 0);
    tick(1);

    // Clear from power-up, then one full frame of colour 0.
    scan_en = 1'b1;
    pulse_clear();
    wait_idle(busy_cycles);
    check("clear_busy_cycles", busy_cycles, NPIX);
    vcnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 20000 && vcnt < NPIX; i++) begin
      if (scan_valid) begin
        vcnt++;
        if (frame_start) fs_cnt++;
      end
      if (vcnt < NPIX) @(negedge clk);
    end
    check("frame_pixels", vcnt, NPIX);
    check("frame_start_count", fs_cnt, 1);
    tick(1);

    // Single plot, then rescan the top rows from (0,0).
    do_plot(5, 3, 3'b100);
    tick(3);
    do_reset(1);
    tick(4 * WIDTH + 10);

    // Out-of-range plots.
    do_plot(160, 0, 3'b111);
`ifdef OOB_FLAG_EN
    @(negedge clk);
    check("oob_set", oob_flag, 1);
    tick(1);
`endif
    do_plot(0, 120, 3'b111);
    tick(5);

    // Fill the FIFO during a clear; the fifth plot must be refused.
    pulse_clear();
`ifdef OOB_FLAG_EN
    @(negedge clk);
    check("oob_cleared", oob_flag, 0);
    tick(1);
`endif
    plot = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_in = 8'(i);
      y_in = 7'd0;
      colour_in = 3'b010;
      tick(1);
    end
    plot = 1'b0;
    @(negedge clk);
    check("ready_full", ready, 0);
    wait_idle(busy_cycles);
    tick(1);
    inv0 = invalid_cnt;
    tick(6);
    check("drain_stall_cycles", invalid_cnt - inv0, 4);
    tick(2);
    do_reset(1);
    tick(WIDTH + 10);

    // Three back-to-back plots steal exactly three scan slots.
    inv0 = invalid_cnt;
    plot = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_in = 8'(20 + i);
      y_in = 7'd1;
      colour_in = 3'(5 + i);
      tick(1);
    end
    plot = 1'b0;
    tick(7);
    check("b2b_stall_cycles", invalid_cnt - inv0, 3);

    // Reset mid-clear with two plots pending.
    pulse_clear();
    tick(50);
    do_plot(10, 0, 3'b111);
    do_plot(11, 0, 3'b111);
    check("pending_before_reset", pend_q.size(), 2);
    do_reset(1);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_scan_valid", scan_valid, 0);
    tick(1);
    tick(2 * WIDTH + 10);

    // Random plots, some out of range, with random scan enable.
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 3));
      scan_en = ($urandom_range(0, 3) != 0);
      do_plot($urandom_range(0, 169), $urandom_range(0, 124), 3'($urandom_range(0, 7)));
    end
    scan_en = 1'b1;
    tick(10);
    do_reset(1);
    tick(6 * WIDTH);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
